// File: rtl/hash_absorb_engine_if.sv
// rtl/hash_absorb_engine_if.sv - message stream and result handshake bundle for hash_absorb_engine
interface hash_absorb_engine_if;
    logic            msg_valid;
    logic [7:0]      msg_data;
    logic            msg_last;
    logic            msg_ready;
    logic            out_valid;
    logic            out_ready;
    logic [7:0][7:0] h;
    logic [63:0]     C;

    modport master (
        output msg_valid, msg_data, msg_last, out_ready,
        input  msg_ready, out_valid, h, C
    );

    modport slave (
        input  msg_valid, msg_data, msg_last, out_ready,
        output msg_ready, out_valid, h, C
    );
endinterface

// File: rtl/hash_absorb_engine.sv
// rtl/hash_absorb_engine.sv - iterative byte absorb stage mixing into an 8-byte state via AES S-box rounds

// S-box computed algebraically: multiplicative inverse in GF(2^8) (x^254) followed by the affine map.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    always_comb begin
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module hash_absorb_engine #(
    parameter int unsigned ROUNDS = 36,
    parameter logic [63:0] IV     = 64'h3C_D2_69_AA_14_0F_55_34
) (
    input  logic           clk,
    input  logic           rst,
    hash_absorb_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

    state_t          state;
    state_t          state_nx;
    logic [7:0][7:0] h_q;
    logic [63:0]     c_q;
    logic [7:0]      m_q;
    logic            last_q;
    logic [7:0]      r_q;
    logic [2:0]      j_q;
    logic [7:0]      sbox_in;
    logic [7:0]      sbox_out;
    logic            ready_c;
    logic            valid_c;
    logic            accept;
    logic            release_out;
    logic            round_end;

    // j wraps mod 8 naturally; the j=7 step therefore reads the h[0] updated earlier this round
    assign sbox_in   = h_q[j_q + 3'd1] ^ m_q;
    assign round_end = (j_q == 3'd7) && (r_q == 8'(ROUNDS - 1));

    aes_sbox u_sbox (
        .a(sbox_in),
        .s(sbox_out)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        ready_c     = 1'b0;
        valid_c     = 1'b0;
        accept      = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.msg_valid) begin
                    accept   = 1'b1;
                    state_nx = MIX;
                end
            end
            MIX: begin
                if (round_end) state_nx = last_q ? DONE : IDLE;
            end
            DONE: begin
                valid_c = 1'b1;
                if (bus.out_ready) begin
                    release_out = 1'b1;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q    <= IV;
            c_q    <= 64'd0;
            m_q    <= 8'h00;
            last_q <= 1'b0;
            r_q    <= 8'd0;
            j_q    <= 3'd0;
        end else if (accept) begin
            m_q    <= bus.msg_data;
            last_q <= bus.msg_last;
            c_q    <= c_q + 64'd1;
            r_q    <= 8'd0;
            j_q    <= 3'd0;
        end else if (state == MIX) begin
            h_q[j_q] <= sbox_out;
            j_q      <= j_q + 3'd1;
            if (j_q == 3'd7) r_q <= r_q + 8'd1;
        end else if (release_out) begin
            h_q <= IV;
            c_q <= 64'd0;
        end
    end

    assign bus.msg_ready = ready_c;
    assign bus.out_valid = valid_c;
    assign bus.h         = h_q;
    assign bus.C         = c_q;
endmodule

// File: tb/tb_hash_absorb_engine.sv
// tb/tb_hash_absorb_engine.sv - directed bench for hash_absorb_engine with a table-driven absorb model
module tb_hash_absorb_engine;
    localparam logic [63:0] IV_B = 64'h3C_D2_69_AA_14_0F_55_34;
    localparam int          R_B  = 36;
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hash_absorb_engine_if ia();
    hash_absorb_engine_if ib();

    hash_absorb_engine #(.ROUNDS(1), .IV(64'h0)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    hash_absorb_engine dut_b (.clk(clk), .rst(rst), .bus(ib));

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        int idx;
        idx = 2047 - 8 * int'(x);
        return SBOX_FLAT[idx -: 8];
    endfunction

    // Full effect of one message byte on the state: ROUNDS passes over bytes 0..7 in order.
    function automatic logic [63:0] absorb(input logic [63:0] st, input logic [7:0] m, input int rounds);
        logic [7:0] b [8];
        logic [63:0] res;
        for (int k = 0; k < 8; k++) b[k] = st[8*k +: 8];
        for (int r = 0; r < rounds; r++)
            for (int k = 0; k < 8; k++) b[k] = sbox(b[(k + 1) % 8] ^ m);
        for (int k = 0; k < 8; k++) res[8*k +: 8] = b[k];
        return res;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [63:0] mh_a, mc_a, mh_b, mc_b;

    always @(posedge clk) begin
        if (rst) begin
            mh_a <= 64'h0; mc_a <= 64'd0;
            mh_b <= IV_B;  mc_b <= 64'd0;
        end else begin
            if (ia.msg_valid && ia.msg_ready) begin
                mh_a <= absorb(mh_a, ia.msg_data, 1); mc_a <= mc_a + 64'd1;
            end
            if (ia.out_valid && ia.out_ready) begin
                mh_a <= 64'h0; mc_a <= 64'd0;
            end
            if (ib.msg_valid && ib.msg_ready) begin
                mh_b <= absorb(mh_b, ib.msg_data, R_B); mc_b <= mc_b + 64'd1;
            end
            if (ib.out_valid && ib.out_ready) begin
                mh_b <= IV_B; mc_b <= 64'd0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ia.out_valid) begin
                chk("a_model_h", ia.h, mh_a);
                chk("a_model_C", ia.C, mc_a);
                chk("a_excl", 64'(ia.msg_ready), 64'd0);
            end
            if (ib.out_valid) begin
                chk("b_model_h", ib.h, mh_b);
                chk("b_model_C", ib.C, mc_b);
                chk("b_excl", 64'(ib.msg_ready), 64'd0);
            end
        end
    end

    function automatic logic rdy(input bit sel);
        return sel ? ib.msg_ready : ia.msg_ready;
    endfunction

    function automatic logic ovld(input bit sel);
        return sel ? ib.out_valid : ia.out_valid;
    endfunction

    // Presents one byte, completes the handshake, returns at the following falling edge.
    task automatic send(input bit sel, input logic [7:0] d, input logic l);
        int n;
        if (sel) begin ib.msg_valid = 1'b1; ib.msg_data = d; ib.msg_last = l; end
        else     begin ia.msg_valid = 1'b1; ia.msg_data = d; ia.msg_last = l; end
        n = 0;
        while (!rdy(sel) && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) chk("send_timeout", 64'(n), 64'd0);
        @(posedge clk);
        @(negedge clk);
        if (sel) ib.msg_valid = 1'b0; else ia.msg_valid = 1'b0;
    endtask

    // Counts busy cycles after an accept until msg_ready (or out_valid for a last byte) is seen.
    task automatic wait_lat(input bit sel, input bit last, output int lat);
        lat = 0;
        while (!(last ? ovld(sel) : rdy(sel)) && lat < 4000) begin lat++; @(negedge clk); end
    endtask

    task automatic release_out(input bit sel, input logic [63:0] iv, input string tag);
        if (sel) ib.out_ready = 1'b1; else ia.out_ready = 1'b1;
        @(negedge clk);
        if (sel) ib.out_ready = 1'b0; else ia.out_ready = 1'b0;
        chk({tag, "_rel_ready"}, 64'(rdy(sel)), 64'd1);
        chk({tag, "_rel_ovalid"}, 64'(ovld(sel)), 64'd0);
        chk({tag, "_rel_h"}, sel ? ib.h : ia.h, iv);
        chk({tag, "_rel_C"}, sel ? ib.C : ia.C, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [63:0] exp3;
        logic seen;
        ia.msg_valid = 1'b0; ia.msg_data = 8'h00; ia.msg_last = 1'b0; ia.out_ready = 1'b0;
        ib.msg_valid = 1'b0; ib.msg_data = 8'h00; ib.msg_last = 1'b0; ib.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("a_rst_ready", 64'(ia.msg_ready), 64'd1);
        chk("a_rst_ovalid", 64'(ia.out_valid), 64'd0);
        chk("a_rst_h", ia.h, 64'h0);
        chk("a_rst_C", ia.C, 64'd0);
        chk("b_rst_h", ib.h, IV_B);
        chk("b_rst_ready", 64'(ib.msg_ready), 64'd1);

        chk("pin_model_00", absorb(64'h0, 8'h00, 1), 64'hFB63636363636363);
        chk("pin_model_01", absorb(64'h0, 8'h01, 1), 64'hFF7C7C7C7C7C7C7C);

        for (int rep = 0; rep < 2; rep++) begin
            send(1'b0, 8'h00, 1'b1);
            wait_lat(1'b0, 1'b1, lat);
            chk("a00_latency", 64'(lat), 64'd8);
            chk("a00_h", ia.h, 64'hFB63636363636363);
            chk("a00_C", ia.C, 64'd1);
            release_out(1'b0, 64'h0, "a00");
        end

        send(1'b0, 8'h01, 1'b1);
        wait_lat(1'b0, 1'b1, lat);
        chk("a01_latency", 64'(lat), 64'd8);
        chk("a01_h", ia.h, 64'hFF7C7C7C7C7C7C7C);
        chk("a01_C", ia.C, 64'd1);
        release_out(1'b0, 64'h0, "a01");

        exp3 = absorb(absorb(absorb(IV_B, 8'hAA, R_B), 8'hBB, R_B), 8'hCC, R_B);
        send(1'b1, 8'hAA, 1'b0);
        wait_lat(1'b1, 1'b0, lat);
        chk("b1_busy", 64'(lat), 64'd288);
        chk("b1_no_ovalid", 64'(ib.out_valid), 64'd0);
        send(1'b1, 8'hBB, 1'b0);
        wait_lat(1'b1, 1'b0, lat);
        chk("b2_busy", 64'(lat), 64'd288);
        chk("b2_no_ovalid", 64'(ib.out_valid), 64'd0);
        send(1'b1, 8'hCC, 1'b1);
        wait_lat(1'b1, 1'b1, lat);
        chk("b3_busy", 64'(lat), 64'd288);
        chk("b3_C", ib.C, 64'd3);
        chk("b3_h", ib.h, exp3);

        ib.msg_valid = 1'b1; ib.msg_data = 8'h55; ib.msg_last = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_h", ib.h, exp3);
            chk("bp_C", ib.C, 64'd3);
            chk("bp_ready", 64'(ib.msg_ready), 64'd0);
            chk("bp_ovalid", 64'(ib.out_valid), 64'd1);
        end
        ib.msg_valid = 1'b0;
        release_out(1'b1, IV_B, "bp");

        send(1'b1, 8'h5A, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_h", ib.h, IV_B);
        chk("mrst_C", ib.C, 64'd0);
        chk("mrst_ready", 64'(ib.msg_ready), 64'd1);
        seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (ib.out_valid) seen = 1'b1;
        end
        chk("mrst_no_ovalid", 64'(seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hash_absorb_engine.md
# hash_absorb_engine

Iterative absorb stage of the hash pipeline. It accepts a message one byte at a time over a valid/ready stream and mixes each byte into an 8-byte state through repeated AES S-box rounds. It counts the message length in bytes. On the last byte it presents the final state `h` and the size `C` to the downstream final-round stage through a valid/ready output handshake. It uses one shared `aes_sbox` instance, performing one lookup per cycle.

## Interface
- `ROUNDS`, default 36: mixing rounds per message byte; legal range 1..255.
- `IV`, default 64'h3C_D2_69_AA_14_0F_55_34: initial state; `h[j]` = `IV[8j+7:8j]`.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `msg_valid`  in  1  input byte valid.
- `msg_data`  in  8  message byte.
- `msg_last`  in  1  marks the final byte of the message; qualified by `msg_valid`.
- `msg_ready`  out  1  engine can accept a byte.
- `out_valid`  out  1  final state and size are available.
- `out_ready`  in  1  downstream accepts the result.
- `h`  out  [7:0][7:0]  state bytes; `h[j]` is byte j.
- `C`  out  64  message size in bytes.

## Operation
- There is one clock and a synchronous, active-high reset.
- State machine: IDLE, MIX, DONE.
- IDLE:
  - `msg_ready` = 1.
  - On `msg_valid & msg_ready`: latch `m` = `msg_data`, latch `last` = `msg_last`, set `C <= C+1`, set `r <= 0`, `j <= 0`, and go to MIX.
- MIX (one S-box lookup per cycle):
  - Update `h[j] <= S(h[(j+1) mod 8] ^ m)`.
  - The lookup always reads the current register value, so the `j=7` step uses the `h[0]` already updated in this round.
  - `j` increments; on `j==7` it wraps to 0 and `r` increments.
  - After the step with `r==ROUNDS-1` and `j==7`: go to DONE if `last`, otherwise go to IDLE.
- DONE:
  - `out_valid` = 1; `h` and `C` are held stable.
  - On `out_ready`: reload `h <= IV`, set `C <= 0`, and go to IDLE.
- `msg_ready` = 0 in MIX and DONE. Input bytes are never dropped or duplicated.
- Width rules:
  - XOR and S-box operate on 8 bits.
  - `C` is a 64-bit modulo counter and wraps from 2^64-1 to 0 without a flag.
- Every accepted beat carries one byte, so a message has at least 1 byte. A zero-length message cannot be expressed.
- `h` and `C` are continuously driven from the internal registers. Their contents are meaningful only while `out_valid` = 1.

## Timing
- Reset values:
  - State = IDLE, `h` = IV, `C` = 0, `r` = 0, `j` = 0.
  - `msg_ready` = 1 and `out_valid` = 0 in the first cycle after reset.
- A byte accepted at edge t is processed in MIX at edges t+1 .. t+8·ROUNDS.
  - Non-last byte: `msg_ready` is high again in the cycle after edge t+8·ROUNDS.
  - Last byte: `out_valid` is high in the cycle after edge t+8·ROUNDS.
- Throughput is one byte per 8·ROUNDS+1 cycles.
- Handshakes complete on the edge where valid & ready.
  - `out_valid` may be held indefinitely. While it is held, `h` and `C` are stable and `msg_ready` = 0.
  - After the `out_valid & out_ready` edge: `msg_ready` = 1 in the next cycle, with `h` = IV and `C` = 0.
- `msg_valid`, `msg_data` and `msg_last` are ignored when `msg_ready` = 0.
- `rst` has priority over all events, in any state including mid-MIX and DONE.
  - The in-flight message is discarded and no `out_valid` is produced.
- `out_valid` and `msg_ready` are never high together.

## Test plan
- ROUNDS=1, IV=0, one byte 0x00 with `msg_last`:
  - `out_valid` rises 8 cycles after the accept edge.
  - `h[0..6]` = 0x63 and `h[7]` = 0xFB.
  - `C` = 1.
- ROUNDS=1, IV=0, byte 0x01 with `msg_last`:
  - `h[0..6]` = 0x7C and `h[7]` = 0xFF.
  - `C` = 1.
- Defaults, 3-byte message (0xAA, 0xBB, 0xCC with last):
  - `msg_ready` is low for exactly 288 cycles after each accept.
  - `out_valid` appears only after the third byte, with `C` = 3.
  - `h` matches the reference model.
- Backpressure:
  - Hold `out_ready` = 0 for 10 cycles in DONE and drive `msg_valid` = 1 throughout.
  - `h` and `C` stay constant, `msg_ready` = 0, and no byte is accepted.
  - Raise `out_ready`: the next cycle shows `msg_ready` = 1, `h` = IV, `C` = 0.
- Back-to-back messages: repeat the first scenario twice.
  - Identical `h` and `C` = 1 both times, proving the state reinitialises.
- Reset mid-MIX:
  - Assert `rst` at cycle 4 of a byte's MIX.
  - Next cycle: `h` = IV, `C` = 0, `msg_ready` = 1, and no `out_valid` occurs.
